// File: rtl/hazard_scoreboard.sv
// Pipeline hazard scoreboard: tracks the EXE and MEM destinations and raises a
// combinational stall request when the ID-stage instruction depends on them.
module hazard_scoreboard (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  src1,
  input  logic [4:0]  src2,
  input  logic        two_src,
  input  logic [4:0]  dest_id,
  input  logic        wb_en_id,
  input  logic        mem_r_en_id,
  input  logic        forward_en,
  input  logic        flush,
  output logic        hazard_detected,
  output logic [4:0]  exe_dest,
  output logic [4:0]  mem_dest,
  output logic [15:0] stall_count
);

  logic [4:0]  r_exe_dest;
  logic        r_exe_wb;
  logic        r_exe_mr;
  logic [4:0]  r_mem_dest;
  logic        r_mem_wb;
  logic [15:0] r_stall_cnt;

  logic w_exe_valid;
  logic w_mem_valid;
  logic w_exe_hit;
  logic w_mem_hit;
  logic w_hazard;

  always_comb begin
    w_exe_valid = r_exe_wb && (r_exe_dest != '0);
    w_mem_valid = r_mem_wb && (r_mem_dest != '0);
    w_exe_hit   = w_exe_valid &&
                  ((r_exe_dest == src1) || (two_src && (r_exe_dest == src2)));
    w_mem_hit   = w_mem_valid &&
                  ((r_mem_dest == src1) || (two_src && (r_mem_dest == src2)));
    // With forwarding only a load in EXE cannot be bypassed in time.
    if (forward_en) begin
      w_hazard = w_exe_hit && r_exe_mr;
    end else begin
      w_hazard = w_exe_hit || w_mem_hit;
    end
  end

  assign hazard_detected = w_hazard;
  assign exe_dest        = r_exe_wb ? r_exe_dest : '0;
  assign mem_dest        = r_mem_wb ? r_mem_dest : '0;
  assign stall_count     = r_stall_cnt;

  // The MEM slot's load flag never influences a decision, so it is not stored.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_exe_dest <= '0;
      r_exe_wb   <= 1'b0;
      r_exe_mr   <= 1'b0;
      r_mem_dest <= '0;
      r_mem_wb   <= 1'b0;
    end else begin
      r_mem_dest <= r_exe_dest;
      r_mem_wb   <= r_exe_wb;
      if (!w_hazard && !flush) begin
        r_exe_dest <= dest_id;
        r_exe_wb   <= wb_en_id;
        r_exe_mr   <= mem_r_en_id;
      end else begin
        r_exe_dest <= '0;
        r_exe_wb   <= 1'b0;
        r_exe_mr   <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cnt <= '0;
    end else if (w_hazard && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed self-checking bench for hazard_scoreboard.
`timescale 1ns/1ps
module tb_hazard_scoreboard;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [4:0]  src1 = '0;
  logic [4:0]  src2 = '0;
  logic        two_src = 1'b0;
  logic [4:0]  dest_id = '0;
  logic        wb_en_id = 1'b0;
  logic        mem_r_en_id = 1'b0;
  logic        forward_en = 1'b0;
  logic        flush = 1'b0;
  logic        hazard_detected;
  logic [4:0]  exe_dest;
  logic [4:0]  mem_dest;
  logic [15:0] stall_count;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  hazard_scoreboard dut (
    .clk(clk), .rst(rst), .src1(src1), .src2(src2), .two_src(two_src),
    .dest_id(dest_id), .wb_en_id(wb_en_id), .mem_r_en_id(mem_r_en_id),
    .forward_en(forward_en), .flush(flush), .hazard_detected(hazard_detected),
    .exe_dest(exe_dest), .mem_dest(mem_dest), .stall_count(stall_count)
  );

  task automatic set_id(input logic [4:0] s1, input logic [4:0] s2, input logic two,
                        input logic [4:0] d, input logic wb, input logic mr);
    src1 = s1; src2 = s2; two_src = two; dest_id = d; wb_en_id = wb; mem_r_en_id = mr;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    set_id(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    flush = 1'b0;
    #1 rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++; if (hazard_detected !== 1'b0) begin errors++; $display("FAIL rst_hazard got=%0b exp=0", hazard_detected); end
    checks++; if (exe_dest !== 5'd0) begin errors++; $display("FAIL rst_exe_dest got=%0d exp=0", exe_dest); end
    checks++; if (mem_dest !== 5'd0) begin errors++; $display("FAIL rst_mem_dest got=%0d exp=0", mem_dest); end
    checks++; if (stall_count !== 16'd0) begin errors++; $display("FAIL rst_count got=%0d exp=0", stall_count); end
  endtask

  task automatic test_load_use();
    do_reset();
    forward_en = 1'b1;
    set_id(5'd0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1);           // LD r5
    #1;
    checks++; if (hazard_detected !== 1'b0) begin errors++; $display("FAIL lu_first got=%0b exp=0", hazard_detected); end
    @(negedge clk);
    set_id(5'd5, 5'd0, 1'b0, 5'd6, 1'b1, 1'b0);           // ADD r6 <- r5
    #1;
    checks++; if (hazard_detected !== 1'b1) begin errors++; $display("FAIL lu_stall got=%0b exp=1", hazard_detected); end
    checks++; if (exe_dest !== 5'd5) begin errors++; $display("FAIL lu_exe_ld got=%0d exp=5", exe_dest); end
    @(negedge clk); #1;
    checks++; if (hazard_detected !== 1'b0) begin errors++; $display("FAIL lu_release got=%0b exp=0", hazard_detected); end
    checks++; if (exe_dest !== 5'd0) begin errors++; $display("FAIL lu_bubble got=%0d exp=0", exe_dest); end
    checks++; if (mem_dest !== 5'd5) begin errors++; $display("FAIL lu_mem_ld got=%0d exp=5", mem_dest); end
    checks++; if (stall_count !== 16'd1) begin errors++; $display("FAIL lu_count got=%0d exp=1", stall_count); end
    @(negedge clk);
    set_id(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    #1;
    checks++; if (exe_dest !== 5'd6) begin errors++; $display("FAIL lu_exe_add got=%0d exp=6", exe_dest); end
  endtask

  task automatic test_no_forward();
    do_reset();
    forward_en = 1'b0;
    set_id(5'd0, 5'd0, 1'b0, 5'd3, 1'b1, 1'b0);           // ADD r3
    @(negedge clk);
    set_id(5'd3, 5'd3, 1'b0, 5'd9, 1'b1, 1'b0);           // src2=3 ignored, src1=3 not: check src2 gating below
    set_id(5'd1, 5'd3, 1'b0, 5'd4, 1'b1, 1'b0);
    #1;
    checks++; if (hazard_detected !== 1'b0) begin errors++; $display("FAIL nf_src2_gated got=%0b exp=0", hazard_detected); end
    two_src = 1'b1;                                        // SUB r4 <- r1,r3
    #1;
    checks++; if (hazard_detected !== 1'b1) begin errors++; $display("FAIL nf_stall1 got=%0b exp=1", hazard_detected); end
    @(negedge clk); #1;
    checks++; if (hazard_detected !== 1'b1) begin errors++; $display("FAIL nf_stall2 got=%0b exp=1", hazard_detected); end
    checks++; if (mem_dest !== 5'd3) begin errors++; $display("FAIL nf_mem got=%0d exp=3", mem_dest); end
    @(negedge clk); #1;
    checks++; if (hazard_detected !== 1'b0) begin errors++; $display("FAIL nf_release got=%0b exp=0", hazard_detected); end
    checks++; if (stall_count !== 16'd2) begin errors++; $display("FAIL nf_count got=%0d exp=2", stall_count); end
  endtask

  task automatic test_distance2();
    do_reset();
    forward_en = 1'b0;
    set_id(5'd0, 5'd0, 1'b0, 5'd8, 1'b1, 1'b0);           // ADD r8
    @(negedge clk);
    set_id(5'd0, 5'd0, 1'b0, 5'd9, 1'b1, 1'b0);           // ADD r9 (independent)
    @(negedge clk);
    set_id(5'd8, 5'd0, 1'b0, 5'd10, 1'b1, 1'b0);          // uses r8 at distance 2
    #1;
    checks++; if (hazard_detected !== 1'b1) begin errors++; $display("FAIL d2_stall got=%0b exp=1", hazard_detected); end
    forward_en = 1'b1;                                     // MEM match is forwardable
    #1;
    checks++; if (hazard_detected !== 1'b0) begin errors++; $display("FAIL d2_fwd got=%0b exp=0", hazard_detected); end
    forward_en = 1'b0;
    @(negedge clk); #1;
    checks++; if (hazard_detected !== 1'b0) begin errors++; $display("FAIL d2_release got=%0b exp=0", hazard_detected); end
    checks++; if (stall_count !== 16'd1) begin errors++; $display("FAIL d2_count got=%0d exp=1", stall_count); end
  endtask

  task automatic test_forward_toggle();
    do_reset();
    forward_en = 1'b1;
    set_id(5'd0, 5'd0, 1'b0, 5'd3, 1'b1, 1'b0);           // non-load ADD r3
    @(negedge clk);
    set_id(5'd3, 5'd0, 1'b0, 5'd4, 1'b1, 1'b0);
    #1;
    checks++; if (hazard_detected !== 1'b0) begin errors++; $display("FAIL ft_fwd_alu got=%0b exp=0", hazard_detected); end
    forward_en = 1'b0;
    #1;
    checks++; if (hazard_detected !== 1'b1) begin errors++; $display("FAIL ft_nofwd got=%0b exp=1", hazard_detected); end
    forward_en = 1'b1;
    #1;
    checks++; if (hazard_detected !== 1'b0) begin errors++; $display("FAIL ft_back got=%0b exp=0", hazard_detected); end
    checks++; if (exe_dest !== 5'd3) begin errors++; $display("FAIL ft_slot got=%0d exp=3", exe_dest); end
  endtask

  task automatic test_reg_zero();
    do_reset();
    forward_en = 1'b0;
    set_id(5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1);           // LD r0
    @(negedge clk);
    set_id(5'd0, 5'd0, 1'b1, 5'd2, 1'b1, 1'b0);           // ADD r2 <- r0,r0
    #1;
    checks++; if (hazard_detected !== 1'b0) begin errors++; $display("FAIL z_nofwd got=%0b exp=0", hazard_detected); end
    forward_en = 1'b1;
    #1;
    checks++; if (hazard_detected !== 1'b0) begin errors++; $display("FAIL z_fwd got=%0b exp=0", hazard_detected); end
    checks++; if (exe_dest !== 5'd0) begin errors++; $display("FAIL z_exe got=%0d exp=0", exe_dest); end
  endtask

  task automatic test_flush();
    do_reset();
    forward_en = 1'b1;
    set_id(5'd0, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1);           // LD r7
    @(negedge clk);
    set_id(5'd7, 5'd0, 1'b0, 5'd10, 1'b1, 1'b0);          // ADDI r10 <- r7, squashed
    flush = 1'b1;
    #1;
    checks++; if (hazard_detected !== 1'b1) begin errors++; $display("FAIL fl_hazard got=%0b exp=1", hazard_detected); end
    @(negedge clk);
    flush = 1'b0;
    set_id(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    #1;
    checks++; if (mem_dest !== 5'd7) begin errors++; $display("FAIL fl_mem got=%0d exp=7", mem_dest); end
    checks++; if (exe_dest !== 5'd0) begin errors++; $display("FAIL fl_exe got=%0d exp=0", exe_dest); end
    checks++; if (stall_count !== 16'd1) begin errors++; $display("FAIL fl_count got=%0d exp=1", stall_count); end
    set_id(5'd0, 5'd0, 1'b0, 5'd11, 1'b1, 1'b0);          // flush without hazard still squashes
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    set_id(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    #1;
    checks++; if (exe_dest !== 5'd0) begin errors++; $display("FAIL fl_squash got=%0d exp=0", exe_dest); end
    checks++; if (mem_dest !== 5'd0) begin errors++; $display("FAIL fl_one_bubble got=%0d exp=0", mem_dest); end
    checks++; if (stall_count !== 16'd1) begin errors++; $display("FAIL fl_count2 got=%0d exp=1", stall_count); end
  endtask

  task automatic test_async_reset();
    do_reset();
    forward_en = 1'b0;
    set_id(5'd0, 5'd0, 1'b0, 5'd3, 1'b1, 1'b0);
    @(negedge clk);
    set_id(5'd3, 5'd0, 1'b0, 5'd4, 1'b1, 1'b0);
    @(negedge clk); #1;
    checks++; if (hazard_detected !== 1'b1) begin errors++; $display("FAIL ar_pre got=%0b exp=1", hazard_detected); end
    #1 rst = 1'b1;
    #1;
    checks++; if (hazard_detected !== 1'b0) begin errors++; $display("FAIL ar_hazard got=%0b exp=0", hazard_detected); end
    checks++; if (exe_dest !== 5'd0) begin errors++; $display("FAIL ar_exe got=%0d exp=0", exe_dest); end
    checks++; if (mem_dest !== 5'd0) begin errors++; $display("FAIL ar_mem got=%0d exp=0", mem_dest); end
    checks++; if (stall_count !== 16'd0) begin errors++; $display("FAIL ar_count got=%0d exp=0", stall_count); end
    #1 rst = 1'b0;
    @(negedge clk); #1;
    checks++; if (hazard_detected !== 1'b0) begin errors++; $display("FAIL ar_resume got=%0b exp=0", hazard_detected); end
    checks++; if (exe_dest !== 5'd4) begin errors++; $display("FAIL ar_exe_load got=%0d exp=4", exe_dest); end
  endtask

  task automatic test_saturation();
    logic [15:0] exp_cnt;
    logic        exp_haz;
    do_reset();
    forward_en = 1'b0;
    set_id(5'd5, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0);           // self-dependent: stalls 2 of every 3 cycles
    force dut.r_stall_cnt = 16'hFFF0;
    #1 release dut.r_stall_cnt;
    exp_cnt = 16'hFFF0;
    #1;
    for (int i = 0; i < 60; i++) begin
      exp_haz = ((i % 3) != 0);
      checks++; if (hazard_detected !== exp_haz) begin errors++; $display("FAIL sat_haz[%0d] got=%0b exp=%0b", i, hazard_detected, exp_haz); end
      checks++; if (stall_count !== exp_cnt) begin errors++; $display("FAIL sat_cnt[%0d] got=%h exp=%h", i, stall_count, exp_cnt); end
      if (exp_haz && exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
      @(negedge clk); #1;
    end
    checks++; if (stall_count !== 16'hFFFF) begin errors++; $display("FAIL sat_final got=%h exp=ffff", stall_count); end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_no_forward();
    test_distance2();
    test_forward_toggle();
    test_reg_zero();
    test_flush();
    test_async_reset();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
